// File: rtl/vector_sequencer.sv
// vector_sequencer: stores up to DEPTH stimulus vectors and applies them one at
// a time to a combinational DUT. After each vector it waits SETTLE cycles, then
// captures dut_out and offers it on a valid/ready result stream.
// Optional feature macro VSEQ_COMPARE_EN adds an expected-response memory, a
// per-result mismatch flag, a saturating mismatch tally and the first failing
// index. With the macro undefined the block is capture-only.
module vector_sequencer #(
    parameter int IN_WIDTH  = 50,
    parameter int OUT_WIDTH = 22,
    parameter int DEPTH     = 1024,
    parameter int SETTLE    = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [AW-1:0]        ld_addr,
    input  logic [IN_WIDTH-1:0]  ld_stim,
    input  logic [OUT_WIDTH-1:0] ld_exp,
    input  logic                 start,
    input  logic                 abort,
    input  logic [AW:0]          num_vectors,
    output logic                 busy,
    output logic                 done,
    output logic [IN_WIDTH-1:0]  dut_in,
    input  logic [OUT_WIDTH-1:0] dut_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [AW-1:0]        res_index,
    output logic [OUT_WIDTH-1:0] res_data,
    output logic                 res_mismatch,
    output logic [AW:0]          mismatch_count,
    output logic [AW:0]          first_fail
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_APPLY  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_EMIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // Settle counter counts down from SETTLE-1; needs at least one bit.
    localparam int              SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [AW:0]     DEPTH_CNT   = DEPTH[AW:0];

    logic [2:0]          state;
    logic [AW-1:0]       idx;
    logic [AW:0]         count;
    logic [SW-1:0]       settle_cnt;
    logic [IN_WIDTH-1:0] stim_mem [DEPTH];

    logic                ld_we;
    logic                last_vec;
    logic                settle_done;
    logic [AW:0]         start_count;

    assign ld_ready  = (state == S_IDLE);
    assign busy      = (state == S_APPLY) || (state == S_SETTLE) || (state == S_EMIT);
    assign done      = (state == S_DONE);
    assign res_valid = (state == S_EMIT);

    // Out-of-range addresses only exist when DEPTH is not a power of two.
    assign ld_we       = ld_valid && ld_ready && (32'(ld_addr) < DEPTH);
    assign start_count = (32'(num_vectors) > DEPTH) ? DEPTH_CNT : num_vectors;
    assign last_vec    = ({1'b0, idx} == (count - 1'b1));
    assign settle_done = (settle_cnt == '0);

    // Stimulus memory: write-only from the load port, not touched by reset.
    always_ff @(posedge clk) begin
        if (ld_we)
            stim_mem[ld_addr] <= ld_stim;
    end

    // Run sequencer: apply, settle, emit per vector; abort beats everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            count      <= '0;
            settle_cnt <= '0;
            dut_in     <= '0;
            res_data   <= '0;
            res_index  <= '0;
        end else if (abort && (state != S_IDLE)) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        count <= start_count;
                        idx   <= '0;
                        state <= (start_count == '0) ? S_DONE : S_APPLY;
                    end
                end
                S_APPLY: begin
                    dut_in     <= stim_mem[idx];
                    settle_cnt <= SETTLE_LAST;
                    state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_done) begin
                        res_data  <= dut_out;
                        res_index <= idx;
                        state     <= S_EMIT;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                S_EMIT: begin
                    if (res_ready) begin
                        if (last_vec) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_APPLY;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef VSEQ_COMPARE_EN
    logic [OUT_WIDTH-1:0] exp_mem [DEPTH];

    // Expected-response memory shares the load strobe with the stimulus.
    always_ff @(posedge clk) begin
        if (ld_we)
            exp_mem[ld_addr] <= ld_exp;
    end

    // Mismatch flag at capture; tally and first failure on the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_mismatch   <= 1'b0;
            mismatch_count <= '0;
            first_fail     <= '1;
        end else if (state == S_IDLE) begin
            if (start) begin
                mismatch_count <= '0;
                first_fail     <= '1;
            end
        end else if (!abort) begin
            if ((state == S_SETTLE) && settle_done)
                res_mismatch <= (dut_out != exp_mem[idx]);
            // All-ones is never a valid index, so it doubles as "no failure yet".
            if ((state == S_EMIT) && res_ready && res_mismatch) begin
                if (mismatch_count != '1)
                    mismatch_count <= mismatch_count + 1'b1;
                if (first_fail == '1)
                    first_fail <= {1'b0, idx};
            end
        end
    end
`else
    logic unused_exp;

    assign unused_exp     = ^ld_exp;
    assign res_mismatch   = 1'b0;
    assign mismatch_count = '0;
    assign first_fail     = '1;
`endif

endmodule
